// File: rtl/shiftadd_iter_hs.sv
// Iterative shift-add modular reducer: folds x = hi*2^k + lo into hi*(2^k - m) + lo
// until x < 2^k, then applies one conditional subtract. Valid/ready on both sides.
module shiftadd_iter_hs #(
  parameter  int W        = 64,
  parameter  int MAX_ITER = 128,
  localparam int KW       = $clog2(W + 1),
  localparam int IW       = $clog2(MAX_ITER + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  x_i,
  input  logic [W-1:0]  m_i,
  input  logic [KW-1:0] m_bl_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  result_o,
  output logic [IW-1:0] iters_o,
  output logic          err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [W:0] ACC_ONE = {{W{1'b0}}, 1'b1};

  state_e        state_r;
  state_e        state_nxt_s;

  logic [W:0]    acc_r;
  logic [W-1:0]  m_r;
  logic [KW-1:0] k_r;
  logic [W:0]    c_r;
  logic [IW-1:0] cnt_r;
  logic          cfg_err_r;

  logic [W-1:0]  result_r;
  logic [IW-1:0] iters_r;
  logic          err_r;
  logic          in_ready_r;
  logic          out_valid_r;

  logic          accept_s;
  logic          msb_set_s;
  logic [W-1:0]  m_above_s;
  logic          cfg_bad_s;
  logic [W:0]    c_in_s;
  logic [W:0]    pow_k_s;
  logic [W:0]    lo_mask_s;
  logic [W:0]    hi_s;
  logic [W:0]    lo_s;
  logic [W:0]    fold_s;
  logic          big_s;
  logic          at_limit_s;
  logic [W-1:0]  acc_lo_s;
  logic [W-1:0]  reduced_s;

  assign accept_s = in_valid_i && in_ready_r;

  // Operand configuration check and fold constant, evaluated on the live inputs
  always_comb begin
    // Shifts by k >= W yield zero, so out-of-range k falls out as "msb not set".
    msb_set_s = |(m_i & (W'(1) << (m_bl_i - KW'(1))));
    m_above_s = m_i >> m_bl_i;
    cfg_bad_s = (m_bl_i == KW'(0)) || (m_bl_i > KW'(W)) || !msb_set_s
                || (m_above_s != {W{1'b0}});
    c_in_s    = (ACC_ONE << m_bl_i) - {1'b0, m_i};
  end

  // Fold datapath on the latched accumulator; W+1 bits holds hi*c + lo exactly
  always_comb begin
    pow_k_s    = ACC_ONE << k_r;
    lo_mask_s  = pow_k_s - ACC_ONE;
    hi_s       = acc_r >> k_r;
    lo_s       = acc_r & lo_mask_s;
    fold_s     = hi_s * c_r + lo_s;
    big_s      = (hi_s != {(W+1){1'b0}});
    at_limit_s = (cnt_r == IW'(MAX_ITER));
    acc_lo_s   = acc_r[W-1:0];
    reduced_s  = (acc_lo_s >= m_r) ? (acc_lo_s - m_r) : acc_lo_s;
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state decision
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_FOLD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FOLD: begin
        // A bad operand spends its one FOLD cycle reporting the error.
        if (cfg_err_r) begin
          state_nxt_s = S_DONE;
        end else if (big_s && !at_limit_s) begin
          state_nxt_s = S_FOLD;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Operand latch, fold iteration and result capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_r     <= {(W+1){1'b0}};
      m_r       <= {W{1'b0}};
      k_r       <= {KW{1'b0}};
      c_r       <= {(W+1){1'b0}};
      cnt_r     <= {IW{1'b0}};
      cfg_err_r <= 1'b0;
      result_r  <= {W{1'b0}};
      iters_r   <= {IW{1'b0}};
      err_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            acc_r     <= {1'b0, x_i};
            m_r       <= m_i;
            k_r       <= m_bl_i;
            c_r       <= c_in_s;
            cnt_r     <= {IW{1'b0}};
            cfg_err_r <= cfg_bad_s;
          end
        end
        S_FOLD: begin
          if (cfg_err_r) begin
            result_r <= {W{1'b0}};
            iters_r  <= {IW{1'b0}};
            err_r    <= 1'b1;
          end else if (big_s && at_limit_s) begin
            result_r <= {W{1'b0}};
            iters_r  <= IW'(MAX_ITER);
            err_r    <= 1'b1;
          end else if (big_s) begin
            acc_r <= fold_s;
            cnt_r <= cnt_r + IW'(1);
          end else begin
            result_r <= reduced_s;
            iters_r  <= cnt_r;
            err_r    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Handshake flags registered from the next state so they track state_r exactly
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_nxt_s == S_IDLE);
      out_valid_r <= (state_nxt_s == S_DONE);
    end
  end

  assign in_ready_o  = in_ready_r;
  assign out_valid_o = out_valid_r;
  assign result_o    = result_r;
  assign iters_o     = iters_r;
  assign err_o       = err_r;

endmodule

// File: tb/tb_shiftadd_iter_hs.sv
// Randomized self-checking bench for shiftadd_iter_hs against an arithmetic
// reference (x % m, fold count from the hi*c + lo rule, timeout and config rules).
module tb_shiftadd_iter_hs;

  localparam int W    = 64;
  localparam int MAXI = 4;
  localparam int KW   = 7;
  localparam int IW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  m;
  logic [KW-1:0] mbl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic [IW-1:0] iters;
  logic          err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] e_res;
  int          e_it;
  logic        e_err;
  int          e_lat;

  always #5 clk = ~clk;

  shiftadd_iter_hs #(.W(W), .MAX_ITER(MAXI)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .x_i        (x),
    .m_i        (m),
    .m_bl_i     (mbl),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .iters_o    (iters),
    .err_o      (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: config rule, fold count by the hi*c + lo rule, result as plain x % m
  task automatic model(input logic [63:0] xv, input logic [63:0] mv, input logic [6:0] kv);
    logic [129:0] pk, c, acc, mw;
    int n;
    logic bad;
    mw  = {66'd0, mv};
    bad = (kv == 7'd0) || (kv > 7'd64);
    pk  = 130'd1 << kv;
    if (!bad) bad = (mw < (pk >> 1)) || (mw >= pk);
    if (bad) begin
      e_res = 64'd0; e_it = 0; e_err = 1'b1; e_lat = 1;
    end else begin
      c   = pk - mw;
      acc = {66'd0, xv};
      n   = 0;
      while (acc >= pk && n < MAXI) begin
        acc = (acc / pk) * c + (acc % pk);
        n++;
      end
      if (acc >= pk) begin
        e_res = 64'd0; e_it = MAXI; e_err = 1'b1; e_lat = MAXI + 1;
      end else begin
        e_res = xv % mv; e_it = n; e_err = 1'b0; e_lat = n + 1;
      end
    end
  endtask

  task automatic issue(input logic [63:0] xv, input logic [63:0] mv, input logic [6:0] kv);
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; x = xv; m = mv; mbl = kv;
    model(xv, mv, kv);
    @(negedge clk);
    in_valid = 1'b0;
    x = {$urandom, $urandom}; m = {$urandom, $urandom}; mbl = 7'($urandom);
  endtask

  task automatic expect_out(input string tag);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'(e_lat));
    check({tag, ".res"}, result, e_res);
    check({tag, ".iters"}, 64'(iters), 64'(e_it));
    check({tag, ".err"}, 64'(err), 64'(e_err));
    check({tag, ".busy"}, 64'(in_ready), 64'd0);
  endtask

  task automatic hold_check(input string tag);
    @(negedge clk);
    check({tag, ".hold_v"}, 64'(out_valid), 64'd1);
    check({tag, ".hold_r"}, 64'(in_ready), 64'd0);
    check({tag, ".hold_res"}, result, e_res);
    check({tag, ".hold_it"}, 64'(iters), 64'(e_it));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".idle_v"}, 64'(out_valid), 64'd0);
    check({tag, ".idle_r"}, 64'(in_ready), 64'd1);
  endtask

  task automatic do_op(input logic [63:0] xv, input logic [63:0] mv, input logic [6:0] kv,
                       input int hold, input string tag);
    out_ready = (hold == 0);
    issue(xv, mv, kv);
    expect_out(tag);
    for (int i = 0; i < hold; i++) hold_check(tag);
    release_out(tag);
  endtask

  initial begin
    logic [63:0]  rx, rm;
    logic [127:0] t;
    int           k;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x = 64'd0; m = 64'd0; mbl = 7'd0;
    #12;
    check("rst.in_ready", 64'(in_ready), 64'd1);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result", result, 64'd0);
    check("rst.iters", 64'(iters), 64'd0);
    check("rst.err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1FFF_FFFF_FFFF_FFFF, 7'd61, 0, "mersenne");
    do_op(64'd100, 64'd13, 7'd4, 0, "m13_x100");
    do_op(64'd13,  64'd13, 7'd4, 1, "m13_x13");
    do_op(64'd12,  64'd13, 7'd4, 0, "m13_x12");
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 7'd1, 0, "timeout");
    do_op(64'd100, 64'd13, 7'd0,  0, "cfg_k0");
    do_op(64'd100, 64'd13, 7'd5,  0, "cfg_k5");
    do_op(64'd100, 64'd13, 7'd65, 0, "cfg_k65");

    // Back-pressure: a pending operand must wait until the result is taken
    out_ready = 1'b0;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1FFF_FFFF_FFFF_FFFF, 7'd61);
    expect_out("bp");
    for (int i = 0; i < 5; i++) begin
      hold_check("bp");
      in_valid = 1'b1; x = 64'd100; m = 64'd13; mbl = 7'd4;
    end
    release_out("bp");
    model(64'd100, 64'd13, 7'd4);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.accepted", 64'(in_ready), 64'd0);
    expect_out("bp_next");
    release_out("bp_next");

    // Reset during the second fold of the Mersenne case
    out_ready = 1'b1;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1FFF_FFFF_FFFF_FFFF, 7'd61);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid.in_ready", 64'(in_ready), 64'd1);
    check("rstmid.out_valid", 64'(out_valid), 64'd0);
    check("rstmid.result", result, 64'd0);
    check("rstmid.iters", 64'(iters), 64'd0);
    check("rstmid.err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstmid.no_valid", 64'(out_valid), 64'd0);
    end
    do_op(64'd100, 64'd13, 7'd4, 0, "after_rst");

    for (int n = 0; n < 40; n++) begin
      k  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(40, 64)) : int'($urandom_range(1, 64));
      rm = {$urandom, $urandom};
      t  = ({64'd0, rm} & ((128'd1 << k) - 128'd1)) | (128'd1 << (k - 1));
      rm = t[63:0];
      if ($urandom_range(0, 9) == 0) k = (k < 64) ? k + 1 : 0;
      rx = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rx = rx >> $urandom_range(0, 63);
      do_op(rx, rm, 7'(k), int'($urandom_range(0, 2)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/shiftadd_iter_hs.md
# shiftadd_iter_hs

Parametrised iterative shift-add modular reducer with valid/ready handshakes on both sides. It is the next generation of the shift-add reduction top-level. It reduces x modulo m, where m has bit length k, by repeatedly folding x = hi·2^k + lo into hi·c + lo, with c = 2^k − m, then applying one final conditional subtract. It adds:

- width generalisation,
- an iteration bound with error reporting,
- per-operand configuration checking,
- output back-pressure.

## Interface
- W, 64, operand/modulus width (≥ 2)
- MAX_ITER, 128, maximum fold iterations before abort (≥ 1)
- KW, $clog2(W+1), width of m_bl_i (derived)
- IW, $clog2(MAX_ITER+1), width of iters_o (derived)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- in_valid_i  in  1  operand valid
- in_ready_o  out  1  block can accept an operand (high only in IDLE)
- x_i  in  W  value to reduce
- m_i  in  W  modulus
- m_bl_i  in  KW  bit length k of m_i
- out_valid_o  out  1  result valid (high only in DONE)
- out_ready_i  in  1  consumer accepts result
- result_o  out  W  x mod m; 0 on error
- iters_o  out  IW  number of folds performed
- err_o  out  1  config error or iteration timeout

## Operation
- FSM states: IDLE, FOLD, DONE. All state and output registers are reset asynchronously.
- **IDLE.** in_ready_o = 1. On in_valid_i && in_ready_o (accept):
  - Latch acc = x_i (W+1 bits), m, k, and c = 2^k − m. Clear the iteration counter.
  - Run the config check. The operand is invalid if k == 0, k > W, or bit k−1 of m_i is 0, or any bit ≥ k of m_i is 1.
  - Invalid operand: go to DONE with err = 1, result = 0, iters = 0.
  - Valid operand: go to FOLD.
- **FOLD**, one decision per cycle:
  - acc ≥ 2^k and counter < MAX_ITER: acc ← (acc >> k)·c + (acc mod 2^k); counter++. Stay in FOLD.
  - acc ≥ 2^k and counter == MAX_ITER: go to DONE with err = 1, result = 0, iters = MAX_ITER.
  - acc < 2^k: result ← (acc ≥ m) ? acc − m : acc; err = 0; iters = counter. Go to DONE.
- **DONE.** out_valid_o = 1. result_o, iters_o and err_o are stable and held while out_ready_i = 0. On out_ready_i = 1, go to IDLE.
- Arithmetic rules:
  - hi < 2^(W−k) and c ≤ 2^(k−1), so hi·c + lo < 2^(W+1). acc is W+1 bits internally and never truncates.
  - Each fold strictly decreases acc while hi > 0, so the loop terminates.
- in_valid_i is ignored outside IDLE. Operand inputs are sampled only at accept; later changes have no effect.
- Outputs are registered. result_o, iters_o and err_o keep the last result until the next DONE entry.

## Timing
- Reset value of every output: in_ready_o = 1 (IDLE), out_valid_o = 0, result_o = 0, iters_o = 0, err_o = 0.
- Reset asserted mid-operation (FOLD or DONE): the block returns to IDLE immediately and asynchronously. The in-flight operand is discarded and no out_valid_o pulse is produced.
- Latency from accept edge to out_valid_o high:
  - n+1 cycles for n folds.
  - 1 cycle on config error.
  - MAX_ITER+1 cycles on timeout.
- Acceptance is not back-to-back within a transaction. The output handshake edge returns the FSM to IDLE, and the next accept is possible on the following edge.
- out_valid_o stays high until out_ready_i is sampled high. A consumer holding out_ready_i high sees a 1-cycle out_valid_o pulse.

## Test plan
- **Mersenne fold.** x = 2^64−1, m = 2^61−1, k = 61, out_ready_i = 1 → result 7, iters 2, err 0, out_valid_o 3 cycles after accept.
- **Small modulus and boundary.**
  - m = 13, k = 4, x = 100 → result 9, iters 2.
  - m = 13, k = 4, x = 13 → result 0, iters 0, latency 1.
  - m = 13, k = 4, x = 12 → result 12.
- **Timeout.** MAX_ITER = 4, m = 1, k = 1, x = 2^64−1 → err 1, result 0, iters 4, latency 5.
- **Config error.** Each of the following → err 1, result 0, iters 0, latency 1:
  - m = 13, k = 0.
  - m = 13, k = 5.
  - m = 13, k = 65.
- **Back-pressure.** Hold out_ready_i low 5 cycles after out_valid_o rises → outputs unchanged and in_ready_o low. A new in_valid_i during this time is not accepted. Raise out_ready_i → IDLE next cycle, then the new operand is accepted.
- **Reset mid-FOLD.** Pulse rst_ni low during the 2nd fold of the Mersenne case → immediate IDLE, all outputs at reset values, no out_valid_o. A subsequent operand x = 100, m = 13, k = 4 → result 9.
